// File: rtl/dump_controller.sv
// Output dump sequencer: takes permuted rate blocks from the previous stage
// and streams them word by word through the output buffer to the consumer.
module dump_controller (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic rate_valid,
  input  logic last_block_in,
  input  logic output_buffer_empty,
  input  logic output_buffer_last_word,
  input  logic dst_ready,
  output logic rate_ack,
  output logic data_out_valid,
  output logic data_out_last,
  output logic output_buffer_we,
  output logic output_buffer_shift_en,
  output logic output_counter_load,
  output logic output_counter_rst,
  output logic last_output_block,
  output logic valid_bytes_reset,
  output logic valid_bytes_enable,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_BLOCK = 2'd1,
    DUMP       = 2'd2,
    DONE       = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   last_flag_q, last_flag_d;

  always_comb begin
    state_d                = state_q;
    last_flag_d            = last_flag_q;
    rate_ack               = 1'b0;
    data_out_valid         = 1'b0;
    data_out_last          = 1'b0;
    output_buffer_we       = 1'b0;
    output_buffer_shift_en = 1'b0;
    output_counter_load    = 1'b0;
    output_counter_rst     = rst;
    last_output_block      = 1'b0;
    valid_bytes_reset      = rst;
    valid_bytes_enable     = 1'b0;
    busy                   = 1'b0;
    done                   = 1'b0;

    // Reset masks every control so a half-finished dump cannot leak out.
    if (!rst) begin
      busy = (state_q != IDLE);
      case (state_q)
        IDLE: begin
          output_counter_rst = 1'b1;
          if (start) begin
            valid_bytes_enable = 1'b1;
            state_d            = WAIT_BLOCK;
          end
        end
        WAIT_BLOCK: begin
          if (rate_valid) begin
            output_buffer_we    = 1'b1;
            output_counter_load = 1'b1;
            rate_ack            = 1'b1;
            last_output_block   = last_block_in;
            last_flag_d         = last_block_in;
            state_d             = DUMP;
          end
        end
        DUMP: begin
          data_out_valid         = ~output_buffer_empty;
          output_buffer_shift_en = ~output_buffer_empty & dst_ready;
          data_out_last          = ~output_buffer_empty & output_buffer_last_word & last_flag_q;
          // An empty buffer here means a zero-word block: leave without output.
          if (output_buffer_empty || (output_buffer_shift_en && output_buffer_last_word))
            state_d = last_flag_q ? DONE : WAIT_BLOCK;
        end
        DONE: begin
          done               = 1'b1;
          valid_bytes_reset  = 1'b1;
          output_counter_rst = 1'b1;
          state_d            = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_flag_q <= last_flag_d;
    end
  end

endmodule

// File: tb/tb_dump_controller.sv
// Scoreboard bench for dump_controller: a behavioural buffer counter and
// producer feed blocks, a negedge monitor checks every accepted word.
module tb_dump_controller;

  logic clk, rst, start, rate_valid, last_block_in, dst_ready;
  logic output_buffer_empty, output_buffer_last_word;
  logic rate_ack, data_out_valid, data_out_last, output_buffer_we, output_buffer_shift_en;
  logic output_counter_load, output_counter_rst, last_output_block;
  logic valid_bytes_reset, valid_bytes_enable, busy, done;

  typedef struct {int blk; int idx; bit last;} wexp_t;
  wexp_t exp_q[$];

  int n_chk, n_err;
  int blk_len, cnt, dr_mode, stim_blk;
  int cyc, n_ack, n_shift, n_valid, n_done, n_gap, n_last;
  int ack_cyc, last_cyc, done_cyc, cur_blk, cur_len, prev_len;
  bit prev_ack, word_seen;
  int s_ack, s_shift, s_valid, s_done, s_gap, s_last;

  dump_controller dut (
    .clk(clk), .rst(rst), .start(start), .rate_valid(rate_valid),
    .last_block_in(last_block_in), .output_buffer_empty(output_buffer_empty),
    .output_buffer_last_word(output_buffer_last_word), .dst_ready(dst_ready),
    .rate_ack(rate_ack), .data_out_valid(data_out_valid), .data_out_last(data_out_last),
    .output_buffer_we(output_buffer_we), .output_buffer_shift_en(output_buffer_shift_en),
    .output_counter_load(output_counter_load), .output_counter_rst(output_counter_rst),
    .last_output_block(last_output_block), .valid_bytes_reset(valid_bytes_reset),
    .valid_bytes_enable(valid_bytes_enable), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath word counter: loads the block length, counts down per shift.
  assign output_buffer_empty     = (cnt == 0);
  assign output_buffer_last_word = (cnt == 1);
  always @(posedge clk) begin
    if (output_counter_rst)       cnt <= 0;
    else if (output_counter_load) cnt <= blk_len;
    else if (output_buffer_shift_en) cnt <= cnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // dst_ready patterns: 0 always ready, 1 ready one cycle in three, 2 stalled.
  initial begin : ready_drv
    int ph;
    ph = 0;
    dst_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (dr_mode)
        0: dst_ready = 1'b1;
        1: begin dst_ready = (ph == 0); ph = (ph + 1) % 3; end
        default: dst_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    wexp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        prev_ack  = 1'b0;
        word_seen = 1'b0;
      end else begin
        chk("shift_rule", output_buffer_shift_en, data_out_valid & dst_ready);
        if (last_output_block) chk("lob_only_on_capture", rate_ack, 1);
        if (rate_ack) chk("lob_matches_last_in", last_output_block, last_block_in);
        if (rate_ack) chk("ack_needs_valid", rate_valid, 1);
        if (prev_ack && prev_len > 0) chk("first_word_latency", data_out_valid, 1);
        prev_ack = rate_ack;
        if (rate_ack) begin
          n_ack++; ack_cyc = cyc; cur_len = blk_len; prev_len = blk_len; cur_blk++;
        end
        if (data_out_valid) n_valid++;
        if (busy && !data_out_valid && !done && word_seen) n_gap++;
        if (done) begin
          n_done++; done_cyc = cyc; word_seen = 1'b0;
          chk("done_outputs", {valid_bytes_reset, output_counter_rst, busy}, 3'b111);
        end
        if (output_buffer_shift_en) begin
          n_shift++;
          word_seen = 1'b1;
          if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_word: got a shift, expected none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("word_blk", cur_blk - 1, e.blk);
            chk("word_idx", cur_len - cnt, e.idx);
            chk("word_last", data_out_last, e.last);
          end
          if (data_out_last) begin n_last++; last_cyc = cyc; end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    chk("start_vbe", valid_bytes_enable, 1);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a block and hold it until acknowledged.
  task automatic send(input int len, input bit last);
    bit got;
    got = 1'b0;
    for (int i = 0; i < len; i++) begin
      wexp_t e;
      e.blk = stim_blk; e.idx = i; e.last = last && (i == len - 1);
      exp_q.push_back(e);
    end
    stim_blk++;
    rate_valid = 1'b1; last_block_in = last; blk_len = len;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      got = rate_ack;
    end
    chk("send_ack_timeout", got, 1);
    @(posedge clk); #1;
    rate_valid = 1'b0; last_block_in = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
    end
    chk(nm, ok, 1);
    tick();
  endtask

  task automatic snap();
    s_ack = n_ack; s_shift = n_shift; s_valid = n_valid;
    s_done = n_done; s_gap = n_gap; s_last = n_last;
  endtask

  task automatic chk_rst_outs(input string nm);
    logic [11:0] v;
    v = {rate_ack, data_out_valid, data_out_last, output_buffer_we, output_buffer_shift_en,
         output_counter_load, output_counter_rst, last_output_block, valid_bytes_reset,
         valid_bytes_enable, busy, done};
    chk(nm, v, 12'h028);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; rate_valid = 1'b0; last_block_in = 1'b0;
    blk_len = 0; dr_mode = 0; stim_blk = 0;
    repeat (2) begin @(negedge clk); chk_rst_outs("reset_outputs"); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {busy, output_counter_rst, valid_bytes_reset, done}, 4'b0100);
    tick();

    // Single short last block, full throughput.
    snap(); do_start(); send(4, 1); wait_idle("t1_finish");
    chk("t1_acks", n_ack - s_ack, 1);
    chk("t1_words", n_shift - s_shift, 4);
    chk("t1_valid_cycles", n_valid - s_valid, 4);
    chk("t1_last_count", n_last - s_last, 1);
    chk("t1_gaps", n_gap - s_gap, 0);
    chk("t1_done_count", n_done - s_done, 1);
    chk("t1_done_latency", done_cyc - last_cyc, 1);
    chk("t1_busy_after", busy, 0);

    // Multi-block: 17 + 17 + 5 words.
    snap(); do_start(); send(17, 0); send(17, 0); send(5, 1); wait_idle("t2_finish");
    chk("t2_acks", n_ack - s_ack, 3);
    chk("t2_words", n_shift - s_shift, 39);
    chk("t2_valid_cycles", n_valid - s_valid, 39);
    chk("t2_gaps", n_gap - s_gap, 2);
    chk("t2_last_count", n_last - s_last, 1);
    chk("t2_done_count", n_done - s_done, 1);

    // Backpressure: ready one cycle in three.
    dr_mode = 1;
    snap(); do_start(); send(21, 1); wait_idle("t3_finish");
    dr_mode = 0;
    chk("t3_words", n_shift - s_shift, 21);
    chk("t3_gaps", n_gap - s_gap, 0);
    chk("t3_stalled", (n_valid - s_valid) >= 61, 1);
    chk("t3_done_count", n_done - s_done, 1);

    // Zero-length last block.
    snap(); do_start(); send(0, 1); wait_idle("t4_finish");
    chk("t4_valid_cycles", n_valid - s_valid, 0);
    chk("t4_done_count", n_done - s_done, 1);
    chk("t4_done_within_2", (done_cyc - ack_cyc >= 1) && (done_cyc - ack_cyc <= 2), 1);

    // Zero-length block in the middle of a dump.
    snap(); do_start(); send(3, 0); send(0, 0); send(2, 1); wait_idle("t4b_finish");
    chk("t4b_acks", n_ack - s_ack, 3);
    chk("t4b_words", n_shift - s_shift, 5);
    chk("t4b_gaps", n_gap - s_gap, 3);
    chk("t4b_last_count", n_last - s_last, 1);

    // Reset mid-dump while stalled on word 7 of 21.
    snap(); do_start(); send(21, 1);
    repeat (6) @(posedge clk);
    #1 dr_mode = 2;
    tick(); tick();
    chk("t5_words_before_reset", n_shift - s_shift, 6);
    chk("t5_valid_held", data_out_valid, 1);
    rst = 1'b1;
    @(negedge clk); chk_rst_outs("t5_reset_cycle1");
    @(negedge clk); chk_rst_outs("t5_reset_cycle2");
    @(posedge clk); #1 rst = 1'b0; dr_mode = 0;
    @(negedge clk);
    chk("t5_idle_after", {busy, done, data_out_valid}, 3'b000);
    chk("t5_no_done", n_done - s_done, 0);
    tick();
    rate_valid = 1'b1; last_block_in = 1'b1; blk_len = 5;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rate_valid = 1'b0; last_block_in = 1'b0;
    chk("t5_no_ack_before_start", n_ack - s_ack, 1);
    snap(); do_start(); send(3, 1); wait_idle("t5_recover_finish");
    chk("t5_recover_words", n_shift - s_shift, 3);
    chk("t5_recover_done", n_done - s_done, 1);

    // Spurious start and rate_valid during DUMP.
    snap(); do_start(); send(17, 1);
    tick();
    start = 1'b1; rate_valid = 1'b1; last_block_in = 1'b0; blk_len = 9;
    tick(); tick();
    start = 1'b0; rate_valid = 1'b0; blk_len = 0;
    wait_idle("t6_finish");
    chk("t6_acks", n_ack - s_ack, 1);
    chk("t6_words", n_shift - s_shift, 17);
    chk("t6_last_count", n_last - s_last, 1);
    chk("t6_done_count", n_done - s_done, 1);
    chk("t6_gaps", n_gap - s_gap, 0);
    tick();
    chk("t6_stays_idle", busy, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
